// File: rtl/counter_checker.sv
// Receive-side checker for a free-running counter stream: acquire, lock, count errors.
// Optional wrap-around counter output is enabled by defining COUNTER_CHECK_WRAP_EN.
module counter_checker #(
  parameter int WIDTH         = 4,
  parameter int LOCK_CNT      = 2,
  parameter int RESYNC_THRESH = 3,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_en,
  input  logic [WIDTH-1:0]     value,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
`ifdef COUNTER_CHECK_WRAP_EN
  ,
  output logic [15:0]          wrap_count
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(RESYNC_THRESH + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [RW-1:0] MISS_LAST = RW'(RESYNC_THRESH - 1);

  typedef enum logic [1:0] {
    ACQ,
    TRACK,
    LOCKED
  } state_e;

  state_e               state_q;
  logic                 locked_q;
  logic                 pulse_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic [WIDTH-1:0]     exp_q;
  logic [MW-1:0]        match_q;
  logic [RW-1:0]        miss_q;

  logic [WIDTH-1:0]     val_inc_d;
  logic [WIDTH-1:0]     exp_inc_d;
  logic                 hit_d;
  logic [ERR_CNT_W-1:0] err_d;

  assign val_inc_d = value + WIDTH'(1);
  assign exp_inc_d = exp_q + WIDTH'(1);
  assign hit_d     = (value == exp_q);
  // Saturating increment: hold at all-ones.
  assign err_d     = (&err_q) ? err_q : err_q + ERR_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACQ;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (in_en) begin
        unique case (state_q)
          ACQ: begin
            exp_q   <= val_inc_d;
            match_q <= '0;
            state_q <= TRACK;
          end
          TRACK: begin
            exp_q <= val_inc_d;
            if (hit_d) begin
              match_q <= match_q + MW'(1);
              if (match_q == LOCK_LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else begin
              match_q <= '0;
            end
          end
          LOCKED: begin
            if (hit_d) begin
              exp_q  <= val_inc_d;
              miss_q <= '0;
            end else begin
              // Flywheel: ignore the bad sample and advance on our own.
              pulse_q <= 1'b1;
              err_q   <= err_d;
              exp_q   <= exp_inc_d;
              if (miss_q == MISS_LAST) begin
                state_q  <= ACQ;
                locked_q <= 1'b0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + RW'(1);
              end
            end
          end
          default: state_q <= ACQ;
        endcase
      end
    end
  end

`ifdef COUNTER_CHECK_WRAP_EN
  logic [15:0] wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= '0;
    end else if (in_en && state_q == LOCKED && hit_d && value == '0) begin
      wrap_q <= wrap_q + 16'd1;
    end
  end

  assign wrap_count = wrap_q;
`endif

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = err_q;
  assign expected  = exp_q;

endmodule
